// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared types and helpers for the AHB5 -> APB4 bridge.
//   htrans_e        : AHB transfer type encoding
//   HSIZE_*         : supported AHB transfer sizes (byte, halfword, word)
//   bridge_state_e  : bridge FSM states
//   calc_pstrb      : APB byte strobes for a transfer
//   size_align_err  : size/alignment legality check done at accept time
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  // Reads never assert strobes; writes mark the byte lanes the size covers.
  function automatic logic [3:0] calc_pstrb(input logic [2:0] size,
                                            input logic [1:0] addr,
                                            input logic       write);
    logic [3:0] strb;
    strb = 4'b0000;
    if (write) begin
      case (size)
        HSIZE_BYTE: strb = 4'b0001 << addr;
        HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
        HSIZE_WORD: strb = 4'b1111;
        default:    strb = 4'b0000;
      endcase
    end
    return strb;
  endfunction

  // Sizes wider than the 32-bit data bus, and misaligned halfwords/words,
  // are rejected without touching the APB side.
  function automatic logic size_align_err(input logic [2:0] size,
                                          input logic [1:0] addr);
    logic err;
    case (size)
      HSIZE_BYTE: err = 1'b0;
      HSIZE_HALF: err = addr[0];
      HSIZE_WORD: err = (addr != 2'b00);
      default:    err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ahb5_to_apb4_bridge.sv
// ---------------------------------------------------------------------------
// ahb5_to_apb4_bridge
// Single-port AHB5 slave; each accepted AHB transfer becomes one APB4
// SETUP/ACCESS transfer. One APB transfer outstanding at a time; AHB wait
// states are held on HREADYOUT until the APB side completes.
//
// Optional build macro: APB_TIMEOUT_EN
//   defined   : ACCESS aborts to an ERROR response after TIMEOUT_CYCLES
//               consecutive PREADY=0 cycles
//   undefined : the bridge waits for PREADY indefinitely
//
// Ports
//   HCLK, HRESETn        clock, synchronous active-low reset
//   HSEL .. HREADY       AHB address/control/write-data inputs
//   HREADYOUT, HRESP,
//   HRDATA               AHB slave response (registered)
//   PADDR .. PPROT       APB requester outputs (registered)
//   PRDATA, PREADY,
//   PSLVERROR            APB completer response
//
// state  | meaning
// IDLE   | no transfer in flight, zero-wait OKAY
// WLATCH | write accepted, capturing HWDATA from the AHB data phase
// SETUP  | APB setup cycle (PSEL=1, PENABLE=0)
// ACCESS | APB access cycle, held until PREADY (or timeout)
// ERR1   | first ERROR response cycle (HREADYOUT=0, HRESP=1)
// ERR2   | second ERROR response cycle (HREADYOUT=1, HRESP=1), may accept
// ---------------------------------------------------------------------------
module ahb5_to_apb4_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [3:0]        HPROT,
  input  logic              HNONSEC,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [3:0]        PSTRB,
  output logic [2:0]        PPROT,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERROR
);

  bridge_state_e state, state_next;
  htrans_e       trans;
  logic          accept;
  logic          accept_err;
  logic          timeout_hit;

  logic          psel_d;
  logic          penable_d;
  logic          hreadyout_d;
  logic          hresp_d;

  logic          unused_sig;

  assign trans      = htrans_e'(HTRANS);
  assign accept     = HSEL && HREADY &&
                      ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ)) &&
                      ((state == ST_IDLE) || (state == ST_ERR2));
  assign accept_err = size_align_err(HSIZE, HADDR[1:0]);

  // HPROT[3:2] (cacheable/bufferable) have no APB4 equivalent.
  assign unused_sig = &{1'b0, HPROT[3:2]};

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Down-counter loaded on the way into SETUP; reaching zero on a wait
  // cycle means TIMEOUT_CYCLES consecutive PREADY=0 cycles have elapsed.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      tmo_cnt <= '0;
    end else if (state_next == ST_SETUP) begin
      tmo_cnt <= TMO_LOAD;
    end else if ((state == ST_ACCESS) && !PREADY && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign timeout_hit = (tmo_cnt == '0);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          if (accept_err) begin
            state_next = ST_ERR1;
          end else if (HWRITE) begin
            state_next = ST_WLATCH;
          end else begin
            state_next = ST_SETUP;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WLATCH: state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          state_next = PSLVERROR ? ST_ERR1 : ST_IDLE;
        end else if (timeout_hit) begin
          state_next = ST_ERR1;
        end
      end
      ST_ERR1:   state_next = ST_ERR2;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state; registered below so every
  // bus-facing output comes straight from a flop.
  always_comb begin
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    case (state_next)
      ST_IDLE:   begin end
      ST_WLATCH: hreadyout_d = 1'b0;
      ST_SETUP: begin
        psel_d      = 1'b1;
        hreadyout_d = 1'b0;
      end
      ST_ACCESS: begin
        psel_d      = 1'b1;
        penable_d   = 1'b1;
        hreadyout_d = 1'b0;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2:   hresp_d = 1'b1;
      default:   begin end
    endcase
  end

  // Registered outputs and APB request capture. The APB request fields are
  // only loaded on a legal accept, so they stay put from SETUP to the end
  // of ACCESS and are untouched by rejected transfers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= 4'b0000;
      PPROT     <= 3'b000;
    end else begin
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;

      if (accept && !accept_err) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
        PSTRB  <= calc_pstrb(HSIZE, HADDR[1:0], HWRITE);
        PPROT  <= {~HPROT[0], HNONSEC, HPROT[1]};
      end

      if (state == ST_WLATCH) begin
        PWDATA <= HWDATA;
      end

      if ((state == ST_ACCESS) && PREADY && !PSLVERROR && !PWRITE) begin
        HRDATA <= PRDATA;
      end
    end
  end

endmodule

// File: doc/ahb5_to_apb4_bridge.md
Name: ahb5_to_apb4_bridge

Overview:
Single-port AHB5 slave that converts each accepted AHB transfer into one APB4 SETUP/ACCESS transfer. It sits downstream of the random AHB5 transaction generator and drives the APB4 signals that the generator's checker compares. One APB transfer is outstanding at a time. AHB wait states are inserted via HREADYOUT until the APB transfer completes.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, data width; fixed at 32, and PSTRB is 4 bits
TIMEOUT_CYCLES, 256, APB PREADY wait limit; used only when APB_TIMEOUT_EN is defined

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESETn  in  1  synchronous active-low reset
HSEL  in  1  slave select
HADDR  in  ADDR_W  AHB address
HTRANS  in  2  transfer type
HWRITE  in  1  write
HSIZE  in  3  transfer size
HPROT  in  4  protection
HNONSEC  in  1  non-secure
HWDATA  in  DATA_W  write data (data phase)
HREADY  in  1  bus-level ready (address-phase qualifier)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  DATA_W  read data
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
PWDATA  out  DATA_W  APB write data
PSTRB  out  4  APB byte strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERROR  in  1  APB slave error

Behaviour:
- Reset (HRESETn low at an edge): state IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; PSEL=0; PENABLE=0; PADDR=0; PWRITE=0; PWDATA=0; PSTRB=0; PPROT=0.
- A reset mid-transfer aborts it: PSEL/PENABLE drop at that edge, and no AHB response is returned.
- All outputs are registered.
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) in IDLE or ERR2. SEQ is handled like NONSEQ, so a burst becomes consecutive single APB transfers.
- IDLE/BUSY transfers, or HSEL=0: no APB activity; HREADYOUT=1 and HRESP=0.
- On accept, capture HADDR, HWRITE, HSIZE, HPROT and HNONSEC.
- Accept-time checks:
  - Error if HSIZE>2.
  - Error if halfword with HADDR[0]=1.
  - Error if word with HADDR[1:0]!=0.
  - On error, go to ERR1; no APB transfer is issued.
- States:
  - IDLE: HREADYOUT=1. Read accept -> SETUP. Write accept -> WLATCH.
  - WLATCH: HREADYOUT=0; PWDATA<=HWDATA at exit; -> SETUP.
  - SETUP: PSEL=1, PENABLE=0; -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; hold while PREADY=0.
    - PREADY & !PSLVERROR: HRDATA<=PRDATA on reads; go to IDLE with HREADYOUT=1, HRESP=0; PSEL/PENABLE drop.
    - PREADY & PSLVERROR: -> ERR1.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0; -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts a new transfer like IDLE; otherwise -> IDLE.
- HREADYOUT=0 throughout WLATCH, SETUP and ACCESS.
- Latency, zero-wait APB:
  - Read: address at edge N; SETUP in cycle N+1, ACCESS in N+2; HREADYOUT=1 with valid HRDATA in N+3.
  - Write: adds one cycle (OKAY in N+4).
- PADDR, PWRITE, PPROT, PSTRB and PWDATA are stable from SETUP through the end of ACCESS.
- PSTRB:
  - Reads: 0000.
  - Byte writes: 0001<<HADDR[1:0].
  - Halfword writes: 0011<<(2*HADDR[1]).
  - Word writes: 1111.
- PPROT: [0]=HPROT[1], [1]=HNONSEC, [2]=~HPROT[0].
- HRDATA holds its value until the next completed read.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: a counter runs in ACCESS while PREADY=0. After TIMEOUT_CYCLES consecutive wait cycles, PSEL/PENABLE drop and the bridge goes to ERR1. The counter clears on entry to SETUP.
- Undefined: the counter is absent, and the bridge waits indefinitely for PREADY.

Decomposition:
- Package ahb_apb_pkg contains:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE_BYTE/HALF/WORD constants.
  - bridge_state_e (IDLE, WLATCH, SETUP, ACCESS, ERR1, ERR2).
  - Function calc_pstrb(size, addr, write) and function size_align_err(size, addr).
- No sub-module; the FSM and datapath sit in one module.

Test Plan:
- Write word 0x0000_1000 with HWDATA 0xDEADBEEF, PREADY=1 -> SETUP then ACCESS with PADDR=0x1000, PWDATA=0xDEADBEEF, PSTRB=1111; OKAY 4 cycles after the address phase.
- Byte write to 0x0000_2003 -> PSTRB=1000. Halfword write to 0x0000_2002 -> PSTRB=1100. Halfword read -> PSTRB=0000.
- Read 0x0000_3000, PREADY low 3 cycles, PRDATA=0x1234_5678 -> ACCESS held 4 cycles, HRDATA=0x1234_5678, HRESP=0.
- PSLVERROR=1 with PREADY -> two-cycle ERROR response (HREADYOUT 0 then 1, HRESP=1). HSIZE=3 or word address 0x0000_0002 -> same ERROR response with PSEL never asserted.
- Back-to-back NONSEQ read then write; HTRANS=BUSY/IDLE -> exactly two APB transfers, and the idle cycles return zero-wait OKAY.
- HRESETn low during ACCESS -> PSEL=0, HREADYOUT=1 at next edge. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck low -> ERROR after 4 wait cycles.
